// File: rtl/kpn_fifo_channel.sv
// rtl/kpn_fifo_channel.sv - parametrised single-clock KPN FIFO channel with status, error and FWFT support
module kpn_fifo_channel #(
  parameter int BITS_NUMBER        = 16,
  parameter int FIFO_ELEMENTS      = 5,
  parameter int ALMOST_FULL_LEVEL  = 28,
  parameter int ALMOST_EMPTY_LEVEL = 4,
  parameter int FWFT               = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr,
  input  logic [BITS_NUMBER-1:0]   entry_1,
  input  logic                     rd,
  output logic [BITS_NUMBER-1:0]   output_1,
  output logic                     output_valid,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [FIFO_ELEMENTS:0]   count,
  output logic                     overflow,
  output logic                     underflow,
  input  logic                     clr_err
);

  localparam int DEPTH = 1 << FIFO_ELEMENTS;
  localparam logic [FIFO_ELEMENTS:0] DEPTH_C = (FIFO_ELEMENTS+1)'(DEPTH);
  localparam logic [FIFO_ELEMENTS:0] AF_C    = (FIFO_ELEMENTS+1)'(ALMOST_FULL_LEVEL);
  localparam logic [FIFO_ELEMENTS:0] AE_C    = (FIFO_ELEMENTS+1)'(ALMOST_EMPTY_LEVEL);

  logic [BITS_NUMBER-1:0]   mem [DEPTH];
  logic [FIFO_ELEMENTS-1:0] w_ptr;
  logic [FIFO_ELEMENTS-1:0] r_ptr;
  logic                     rd_fire;
  logic                     wr_fire;

  // Flags are pure decodes of the registered occupancy so they move with count.
  assign full         = (count == DEPTH_C);
  assign empty        = (count == '0);
  assign almost_full  = (count >= AF_C);
  assign almost_empty = (count <= AE_C);

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a write alongside a read.
  assign rd_fire = rd & ~empty;
  assign wr_fire = wr & (~full | rd_fire);

  // Storage array; contents intentionally survive reset.
  always_ff @(posedge clk) begin
    if (wr_fire) mem[w_ptr] <= entry_1;
  end

  // Pointers advance on accepted operations and wrap at the power-of-two depth.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_ptr <= '0;
      r_ptr <= '0;
    end else begin
      if (wr_fire) w_ptr <= w_ptr + 1'b1;
      if (rd_fire) r_ptr <= r_ptr + 1'b1;
    end
  end

  // Occupancy tracks net accepted writes minus accepted reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else begin
      case ({wr_fire, rd_fire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Sticky error flags; a new error in the clearing cycle takes priority over the clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (clr_err) begin
        overflow  <= 1'b0;
        underflow <= 1'b0;
      end
      if (wr & ~wr_fire) overflow  <= 1'b1;
      if (rd & empty)    underflow <= 1'b1;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head word is presented continuously; rd only acknowledges it.
      assign output_1     = mem[r_ptr];
      assign output_valid = ~empty;
    end else begin : g_std
      // Registered read: data appears the cycle after the pop and holds until the next pop.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          output_1     <= '0;
          output_valid <= 1'b0;
        end else begin
          output_valid <= rd_fire;
          if (rd_fire) output_1 <= mem[r_ptr];
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_kpn_fifo_channel.sv
// tb/tb_kpn_fifo_channel.sv - self-checking bench for kpn_fifo_channel in standard and FWFT modes
module tb_kpn_fifo_channel;

  localparam int DEPTH = 32;

  logic        clk;
  logic        rst_n;

  // Standard-mode instance signals
  logic        wr, rd, clr_err;
  logic [15:0] entry_1, output_1;
  logic        output_valid, full, empty, almost_full, almost_empty, overflow, underflow;
  logic [5:0]  count;

  // FWFT-mode instance signals
  logic        wr_b, rd_b, clr_b;
  logic [15:0] entry_b, output_b;
  logic        valid_b, full_b, empty_b, af_b, ae_b, ov_b, un_b;
  logic [5:0]  count_b;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: queue of stored words plus sticky flags and last standard-mode read
  logic [15:0] q[$];
  logic        m_ov, m_un, m_valid;
  logic [15:0] m_out;

  kpn_fifo_channel #(.BITS_NUMBER(16), .FIFO_ELEMENTS(5), .ALMOST_FULL_LEVEL(28),
                     .ALMOST_EMPTY_LEVEL(4), .FWFT(0)) dut (
    .clk(clk), .rst_n(rst_n), .wr(wr), .entry_1(entry_1), .rd(rd),
    .output_1(output_1), .output_valid(output_valid), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow), .clr_err(clr_err));

  kpn_fifo_channel #(.BITS_NUMBER(16), .FIFO_ELEMENTS(5), .ALMOST_FULL_LEVEL(28),
                     .ALMOST_EMPTY_LEVEL(4), .FWFT(1)) dut_fwft (
    .clk(clk), .rst_n(rst_n), .wr(wr_b), .entry_1(entry_b), .rd(rd_b),
    .output_1(output_b), .output_valid(valid_b), .full(full_b), .empty(empty_b),
    .almost_full(af_b), .almost_empty(ae_b), .count(count_b),
    .overflow(ov_b), .underflow(un_b), .clr_err(clr_b));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic model_reset();
    q.delete();
    m_ov = 1'b0; m_un = 1'b0; m_valid = 1'b0; m_out = 16'h0;
  endtask

  // Drive one cycle on the standard instance and advance the model by one edge.
  task automatic step(input logic w, input logic r, input logic [15:0] d, input logic c);
    logic had_word, can_take;
    wr = w; rd = r; entry_1 = d; clr_err = c;
    @(posedge clk);
    had_word = (q.size() > 0);
    can_take = (q.size() < DEPTH) || (r && had_word);
    if (c) begin m_ov = 1'b0; m_un = 1'b0; end
    if (w && !can_take) m_ov = 1'b1;
    if (r && !had_word) m_un = 1'b1;
    m_valid = r && had_word;
    if (m_valid) m_out = q.pop_front();
    if (w && can_take) q.push_back(d);
    #1;
    wr = 1'b0; rd = 1'b0; clr_err = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    wr = 0; rd = 0; clr_err = 0; entry_1 = 0;
    wr_b = 0; rd_b = 0; clr_b = 0; entry_b = 0;
    model_reset();
    #3;
    n_checks++; if (count !== 6'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", count); end
    n_checks++; if (empty !== 1'b1 || almost_empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b%b expected 11", empty, almost_empty); end
    n_checks++; if (full !== 1'b0 || almost_full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b%b expected 00", full, almost_full); end
    n_checks++; if (output_valid !== 1'b0 || output_1 !== 16'h0) begin n_fail++; $display("FAIL reset_output: got %b/%h expected 0/0000", output_valid, output_1); end
    n_checks++; if (overflow !== 1'b0 || underflow !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b%b expected 00", overflow, underflow); end
    n_checks++; if (valid_b !== 1'b0 || empty_b !== 1'b1) begin n_fail++; $display("FAIL reset_fwft: got valid=%b empty=%b expected 0/1", valid_b, empty_b); end
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < DEPTH; i++) begin
      step(1, 0, 16'(i + 1), 0);
      if (count == 6'd27) begin
        n_checks++; if (almost_full !== 1'b0) begin n_fail++; $display("FAIL af_at_27: got %b expected 0", almost_full); end
      end
      if (count == 6'd28) begin
        n_checks++; if (almost_full !== 1'b1) begin n_fail++; $display("FAIL af_at_28: got %b expected 1", almost_full); end
      end
    end
    n_checks++; if (full !== 1'b1 || count !== 6'd32) begin n_fail++; $display("FAIL fill_full: got full=%b count=%0d expected 1/32", full, count); end
    step(1, 0, 16'hBEEF, 0);
    n_checks++; if (overflow !== 1'b1 || count !== 6'd32) begin n_fail++; $display("FAIL overflow_set: got ov=%b count=%0d expected 1/32", overflow, count); end
    for (int i = 0; i < DEPTH; i++) begin
      step(0, 1, 16'h0, 0);
      n_checks++;
      if (output_valid !== 1'b1 || output_1 !== 16'(i + 1)) begin
        n_fail++; $display("FAIL drain_data[%0d]: got %b/%h expected 1/%h", i, output_valid, output_1, 16'(i + 1));
      end
    end
    step(0, 0, 16'h0, 0);
    n_checks++; if (empty !== 1'b1 || output_valid !== 1'b0 || output_1 !== 16'h0020) begin n_fail++; $display("FAIL drain_end: got empty=%b valid=%b out=%h expected 1/0/0020", empty, output_valid, output_1); end
  endtask

  task automatic test_simultaneous();
    step(0, 0, 16'h0, 1);
    n_checks++; if (overflow !== 1'b0 || underflow !== 1'b0) begin n_fail++; $display("FAIL clr_alone: got %b%b expected 00", overflow, underflow); end
    for (int i = 0; i < DEPTH; i++) step(1, 0, 16'($urandom), 0);
    step(1, 1, 16'h7777, 0);
    n_checks++; if (count !== 6'd32 || overflow !== 1'b0) begin n_fail++; $display("FAIL rw_full_count: got count=%0d ov=%b expected 32/0", count, overflow); end
    n_checks++; if (output_valid !== 1'b1 || output_1 !== m_out) begin n_fail++; $display("FAIL rw_full_data: got %b/%h expected 1/%h", output_valid, output_1, m_out); end
    while (q.size() > 0) begin
      step(0, 1, 16'h0, 0);
      n_checks++; if (output_1 !== m_out) begin n_fail++; $display("FAIL rw_full_drain: got %h expected %h", output_1, m_out); end
    end
    n_checks++; if (output_1 !== 16'h7777) begin n_fail++; $display("FAIL rw_full_last: got %h expected 7777", output_1); end
    step(1, 1, 16'h1234, 0);
    n_checks++; if (count !== 6'd1 || underflow !== 1'b1 || output_valid !== 1'b0) begin n_fail++; $display("FAIL rw_empty: got count=%0d un=%b valid=%b expected 1/1/0", count, underflow, output_valid); end
    step(0, 1, 16'h0, 0);
    n_checks++; if (output_1 !== 16'h1234 || empty !== 1'b1) begin n_fail++; $display("FAIL rw_empty_data: got %h empty=%b expected 1234/1", output_1, empty); end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 20; i++) step(1, 0, 16'(i), 0);
    for (int i = 0; i < 20; i++) step(0, 1, 16'h0, 0);
    for (int i = 0; i < 20; i++) begin
      step(1, 0, 16'(16'h1000 + i), 0);
      step(0, 1, 16'h0, 0);
      n_checks++;
      if (output_valid !== 1'b1 || output_1 !== 16'(16'h1000 + i)) begin
        n_fail++; $display("FAIL wrap_data[%0d]: got %b/%h expected 1/%h", i, output_valid, output_1, 16'(16'h1000 + i));
      end
    end
    n_checks++; if (count !== 6'd0 || empty !== 1'b1) begin n_fail++; $display("FAIL wrap_end: got count=%0d expected 0", count); end
  endtask

  task automatic test_fwft();
    logic [15:0] fq[$];
    logic [15:0] w;
    wr_b = 1; entry_b = 16'hA5A5;
    @(posedge clk); #1; wr_b = 0;
    n_checks++; if (valid_b !== 1'b1 || output_b !== 16'hA5A5) begin n_fail++; $display("FAIL fwft_present: got %b/%h expected 1/a5a5", valid_b, output_b); end
    @(posedge clk); #1;
    n_checks++; if (valid_b !== 1'b1 || output_b !== 16'hA5A5) begin n_fail++; $display("FAIL fwft_hold: got %b/%h expected 1/a5a5", valid_b, output_b); end
    rd_b = 1;
    @(posedge clk); #1; rd_b = 0;
    n_checks++; if (valid_b !== 1'b0 || empty_b !== 1'b1) begin n_fail++; $display("FAIL fwft_pop: got valid=%b empty=%b expected 0/1", valid_b, empty_b); end
    for (int i = 0; i < 5; i++) begin
      w = 16'($urandom); fq.push_back(w);
      wr_b = 1; entry_b = w; @(posedge clk); #1; wr_b = 0;
    end
    while (fq.size() > 0) begin
      w = fq.pop_front();
      n_checks++; if (valid_b !== 1'b1 || output_b !== w) begin n_fail++; $display("FAIL fwft_order: got %b/%h expected 1/%h", valid_b, output_b, w); end
      rd_b = 1; @(posedge clk); #1; rd_b = 0;
    end
    n_checks++; if (empty_b !== 1'b1 || count_b !== 6'd0) begin n_fail++; $display("FAIL fwft_end: got empty=%b count=%0d expected 1/0", empty_b, count_b); end
  endtask

  task automatic test_clr_err();
    step(0, 1, 16'h0, 0);
    step(0, 1, 16'h0, 1);
    n_checks++; if (underflow !== 1'b1) begin n_fail++; $display("FAIL clr_vs_set: got un=%b expected 1", underflow); end
    step(0, 0, 16'h0, 1);
    n_checks++; if (underflow !== 1'b0 || overflow !== 1'b0) begin n_fail++; $display("FAIL clr_after: got %b%b expected 00", overflow, underflow); end
    for (int i = 0; i < 10; i++) step(1, 0, 16'($urandom), 0);
    n_checks++; if (count !== 6'd10) begin n_fail++; $display("FAIL pre_reset_count: got %0d expected 10", count); end
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    n_checks++; if (count !== 6'd0 || empty !== 1'b1) begin n_fail++; $display("FAIL async_reset: got count=%0d empty=%b expected 0/1", count, empty); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    int pct;
    for (int i = 0; i < 600; i++) begin
      pct = ((i / 60) % 2 == 0) ? 80 : 25;
      step($urandom_range(0, 99) < pct, $urandom_range(0, 99) >= pct,
           16'($urandom), $urandom_range(0, 19) == 0);
      n_checks++;
      if (count !== 6'(q.size()) || full !== (q.size() == DEPTH) || empty !== (q.size() == 0) ||
          almost_full !== (q.size() >= 28) || almost_empty !== (q.size() <= 4)) begin
        n_fail++; $display("FAIL rand_status[%0d]: got count=%0d f=%b e=%b af=%b ae=%b expected count=%0d", i, count, full, empty, almost_full, almost_empty, q.size());
      end
      n_checks++;
      if (overflow !== m_ov || underflow !== m_un) begin
        n_fail++; $display("FAIL rand_err[%0d]: got %b%b expected %b%b", i, overflow, underflow, m_ov, m_un);
      end
      n_checks++;
      if (output_valid !== m_valid || output_1 !== m_out) begin
        n_fail++; $display("FAIL rand_data[%0d]: got %b/%h expected %b/%h", i, output_valid, output_1, m_valid, m_out);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_simultaneous();
    test_wrap();
    test_fwft();
    test_clr_err();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/kpn_fifo_channel.md
Name: kpn_fifo_channel

Overview:
- Parametrised single-clock FIFO channel for KPN process-to-process links. It is the successor to the fixed 16x32 channel FIFO.
- Adds:
  - asynchronous active-low reset
  - posedge-only operation
  - legal simultaneous read/write at full and at empty
  - occupancy count and almost-full/almost-empty thresholds
  - sticky overflow/underflow error flags
  - selectable standard or first-word-fall-through (FWFT) read mode
- Sits between a producer node's write port and a consumer node's read port.

Parameters:
- BITS_NUMBER, 16, data word width (1..64).
- FIFO_ELEMENTS, 5, address width; depth DEPTH = 2**FIFO_ELEMENTS (1..10).
- ALMOST_FULL_LEVEL, 28, almost_full asserts when count >= this value (1..DEPTH).
- ALMOST_EMPTY_LEVEL, 4, almost_empty asserts when count <= this value (0..DEPTH-1).
- FWFT, 0, read mode: 0 = standard registered read, 1 = first-word-fall-through.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- wr  in  1  write request.
- entry_1  in  BITS_NUMBER  write data.
- rd  in  1  read request (pop).
- output_1  out  BITS_NUMBER  read data.
- output_valid  out  1  output_1 holds valid data (see Behaviour).
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= ALMOST_FULL_LEVEL.
- almost_empty  out  1  count <= ALMOST_EMPTY_LEVEL.
- count  out  FIFO_ELEMENTS+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky: a write was rejected.
- underflow  out  1  sticky: a read was rejected.
- clr_err  in  1  synchronous clear of overflow/underflow.

Behaviour:
- Reset (rst_n low, asynchronous, no clock needed):
  - w_ptr = r_ptr = 0, count = 0.
  - empty = 1, full = 0, almost_empty = 1, almost_full = 0.
  - output_1 = 0, output_valid = 0 (FWFT=1: output_valid = 0 because empty).
  - overflow = underflow = 0.
  - Memory contents are not reset.
  - Reset mid-operation discards all stored words. Deassertion takes effect at the next posedge.
- Fire conditions (combinational, evaluated per cycle):
  - rd_fire = rd & ~empty.
  - wr_fire = wr & (~full | rd_fire). At full, a simultaneous rd and wr both succeed.
  - At empty, rd and wr together: write accepted, read rejected, underflow set.
- Write: on wr_fire, mem[w_ptr] <= entry_1 and w_ptr <= w_ptr+1. Pointers wrap modulo DEPTH naturally.
- Read: on rd_fire, r_ptr <= r_ptr+1 with modulo wrap.
- Count update:
  - count <= count + wr_fire - rd_fire.
  - Both fire: count unchanged.
  - count never exceeds DEPTH and never goes below 0.
- Status flags are decoded from the registered count, so they change on the same edge as count. No read-during-write bypass affects flags.
- FWFT=0 (standard mode):
  - On rd_fire, output_1 <= mem[r_ptr] at that edge.
  - output_valid is high for exactly the following cycle, i.e. 1-cycle latency.
  - Without rd_fire, output_1 holds its last value and output_valid = 0.
- FWFT=1:
  - output_1 = mem[r_ptr] combinationally; output_valid = ~empty.
  - rd acts as an acknowledge/pop of the currently presented word.
  - A word written into an empty FIFO appears on output_1 the cycle after the write edge.
- Error flags:
  - overflow <= 1 when wr & ~wr_fire.
  - underflow <= 1 when rd & empty.
  - clr_err clears both at the posedge. If set and clear occur in the same cycle, set wins.
  - Rejected operations change no pointer, count or data.
- Thresholds are compared as unsigned values against count (FIFO_ELEMENTS+1 bits).

Test Plan:
- Reset then idle: rst_n=0 asynchronously mid-cycle -> count=0, empty=1, almost_empty=1, full=0, output_valid=0, overflow=underflow=0 immediately, before any clock edge.
- FWFT=0: write 0x0001..0x0020 on 32 consecutive cycles -> full=1, count=32, almost_full rose when count reached 28; a 33rd write 0xBEEF sets overflow=1 with count still 32. Then 32 reads return 0x0001..0x0020 in order, each valid one cycle after rd, then empty=1.
- Simultaneous rd+wr at full (count=32) -> count stays 32, the oldest word is read, the new word is stored, overflow stays 0. Simultaneous rd+wr at empty -> count=1, underflow=1, output_valid=0 next cycle.
- Wrap-around: 20 writes, 20 reads, then 20 writes/reads of 0x1000+i -> data returned in order across the pointer wrap, count ends at 0.
- FWFT=1: write 0xA5A5 into the empty FIFO -> next cycle output_1=0xA5A5 and output_valid=1 without rd. Pulse rd -> output_valid=0 and empty=1.
- clr_err asserted alone -> overflow/underflow clear. clr_err together with rd at empty -> underflow remains 1. rst_n pulsed low with count=10 -> count=0 and empty=1 with no clock edge.
